// File: rtl/tree_plru_set_array.sv
// tree_plru_set_array: per-set tree pseudo-LRU with registered victim query and sequenced flush.
// Optional define TREE_PLRU_INVALID_FIRST_EN picks the lowest invalid way before the tree.
module tree_plru_set_array #(
  parameter int N_WAYS = 4,
  parameter int N_SETS = 8,
  localparam int BW_WAYS = $clog2(N_WAYS),
  localparam int BW_SETS = $clog2(N_SETS)
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               upd_en_i,
  input  logic [BW_SETS-1:0] upd_set_i,
  input  logic [BW_WAYS-1:0] upd_way_i,
  input  logic               qry_en_i,
  input  logic [BW_SETS-1:0] qry_set_i,
`ifdef TREE_PLRU_INVALID_FIRST_EN
  input  logic [N_WAYS-1:0]  valid_i,
  output logic               victim_invalid_o,
`endif
  output logic               victim_valid_o,
  output logic [BW_WAYS-1:0] victim_way_o,
  input  logic               flush_i,
  output logic               ready_o
);
  typedef logic [N_WAYS-2:0] tree_t;
  typedef enum logic {IDLE, SWEEP} state_t;

  tree_t              tree [N_SETS];
  state_t             state, state_nxt;
  logic [BW_SETS-1:0] cnt;
  logic               upd_act, qry_act;
  tree_t              upd_tree, qry_tree;
  logic [BW_WAYS-1:0] walk_way, victim_nxt;

  // Point every node on the path away from the referenced way.
  function automatic tree_t touch(input tree_t t, input logic [BW_WAYS-1:0] way);
    tree_t              r;
    logic [BW_WAYS-1:0] n;
    r = t;
    n = '0;
    for (int k = 0; k < BW_WAYS; k++) begin
      r[n] = ~way[BW_WAYS-1-k];
      n = BW_WAYS'({n, 1'b1} + (BW_WAYS+1)'(way[BW_WAYS-1-k]));
    end
    return r;
  endfunction

  function automatic logic [BW_WAYS-1:0] walk(input tree_t t);
    logic [BW_WAYS-1:0] n, v;
    n = '0;
    v = '0;
    for (int k = 0; k < BW_WAYS; k++) begin
      v[BW_WAYS-1-k] = t[n];
      n = BW_WAYS'({n, 1'b1} + (BW_WAYS+1)'(t[n]));
    end
    return v;
  endfunction

  assign ready_o  = (state == IDLE);
  assign upd_act  = upd_en_i & ready_o;
  assign qry_act  = qry_en_i & ready_o;
  assign upd_tree = touch(tree[upd_set_i], upd_way_i);
  // Same-set update in the query cycle is bypassed so the query sees the new tree.
  assign qry_tree = (upd_act && upd_set_i == qry_set_i) ? upd_tree : tree[qry_set_i];
  assign walk_way = walk(qry_tree);

`ifdef TREE_PLRU_INVALID_FIRST_EN
  logic               any_invalid;
  logic [BW_WAYS-1:0] inv_way;
  always_comb begin
    any_invalid = 1'b0;
    inv_way     = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        any_invalid = 1'b1;
        inv_way     = BW_WAYS'(i);
      end
    end
  end
  assign victim_nxt = any_invalid ? inv_way : walk_way;
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) victim_invalid_o <= 1'b0;
    else if (qry_act) victim_invalid_o <= any_invalid;
  end
`else
  assign victim_nxt = walk_way;
`endif

  always_comb begin
    state_nxt = state;
    if (state == IDLE && flush_i) state_nxt = SWEEP;
    if (state == SWEEP && cnt == BW_SETS'(N_SETS - 1)) state_nxt = IDLE;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == SWEEP) ? cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int s = 0; s < N_SETS; s++) tree[s] <= '0;
    end else if (state == SWEEP) begin
      tree[cnt] <= '0;
    end else if (upd_act) begin
      tree[upd_set_i] <= upd_tree;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else begin
      victim_valid_o <= qry_act;
      if (qry_act) victim_way_o <= victim_nxt;
    end
  end
endmodule

// File: tb/tb_tree_plru_set_array.sv
// tb_tree_plru_set_array: directed scoreboard bench for tree_plru_set_array.
module tb_tree_plru_set_array;
  logic       clock_i = 1'b0;
  logic       resetn_i = 1'b0;
  logic       upd_en_i = 1'b0;
  logic [2:0] upd_set_i = '0;
  logic [1:0] upd_way_i = '0;
  logic       qry_en_i = 1'b0;
  logic [2:0] qry_set_i = '0;
  logic       victim_valid_o;
  logic [1:0] victim_way_o;
  logic       flush_i = 1'b0;
  logic       ready_o;
`ifdef TREE_PLRU_INVALID_FIRST_EN
  logic [3:0] valid_i = 4'b1111;
  logic       victim_invalid_o;
`endif

  int         checks = 0;
  int         failures = 0;
  logic       pend = 1'b0;
  logic [1:0] sb [$];

  tree_plru_set_array #(.N_WAYS(4), .N_SETS(8)) dut (
    .clock_i(clock_i), .resetn_i(resetn_i),
    .upd_en_i(upd_en_i), .upd_set_i(upd_set_i), .upd_way_i(upd_way_i),
    .qry_en_i(qry_en_i), .qry_set_i(qry_set_i),
`ifdef TREE_PLRU_INVALID_FIRST_EN
    .valid_i(valid_i), .victim_invalid_o(victim_invalid_o),
`endif
    .victim_valid_o(victim_valid_o), .victim_way_o(victim_way_o),
    .flush_i(flush_i), .ready_o(ready_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [2:0] s, input logic [1:0] w);
    upd_en_i = 1'b1; upd_set_i = s; upd_way_i = w;
  endtask

  task automatic qry(input logic [2:0] s, input logic [1:0] exp);
    qry_en_i = 1'b1; qry_set_i = s;
    sb.push_back(exp);
    pend = 1'b1;
  endtask

  task automatic tick(input string tag);
    logic ev;
    @(posedge clock_i);
    #1;
    upd_en_i = 1'b0; qry_en_i = 1'b0; flush_i = 1'b0;
    ev = pend;
    pend = 1'b0;
    chk({tag, ":valid"}, 32'(victim_valid_o), 32'(ev));
    if (ev && sb.size() > 0) chk({tag, ":way"}, 32'(victim_way_o), 32'(sb.pop_front()));
  endtask

  initial begin
    #12;
    chk("rst:ready", 32'(ready_o), 32'd1);
    chk("rst:valid", 32'(victim_valid_o), 32'd0);
    chk("rst:way", 32'(victim_way_o), 32'd0);
    resetn_i = 1'b1;
    @(posedge clock_i); #1;

    qry(3'd3, 2'd0); tick("t1_q");
    tick("t1_single_pulse");

    upd(3'd3, 2'd0); tick("t2_u0");
    qry(3'd3, 2'd2); tick("t2_q_after_w0");
    upd(3'd3, 2'd2); tick("t2_u2");
    qry(3'd3, 2'd1); tick("t2_q_after_w2");
    tick("t2_idle");
    chk("t2_way_hold", 32'(victim_way_o), 32'd1);

    for (int w = 0; w < 4; w++) begin
      upd(3'd5, 2'(w)); tick("t3_u");
    end
    qry(3'd5, 2'd0); tick("t3_q5");
    qry(3'd4, 2'd0); tick("t3_q4");

    upd(3'd2, 2'd0); qry(3'd2, 2'd2); tick("t4_bypass");
    upd(3'd2, 2'd0); qry(3'd6, 2'd0); tick("t4_other_set");

    upd(3'd0, 2'd0); tick("t5_dirty0");
    upd(3'd7, 2'd3); tick("t5_dirty7");
    qry(3'd0, 2'd2); tick("t5_q0_dirty");
    flush_i = 1'b1; tick("t5_flush");
    for (int i = 0; i < 8; i++) begin
      chk("t5_ready_low", 32'(ready_o), 32'd0);
      if (i == 7) begin
        upd_en_i = 1'b1; upd_set_i = 3'd0; upd_way_i = 2'd0;
        qry_en_i = 1'b1; qry_set_i = 3'd0;
        flush_i = 1'b1;
      end
      tick("t5_sweep");
    end
    chk("t5_ready_back", 32'(ready_o), 32'd1);
    tick("t5_no_queued_flush");
    chk("t5_ready_stays", 32'(ready_o), 32'd1);
    qry(3'd0, 2'd0); tick("t5_q0");
    qry(3'd7, 2'd0); tick("t5_q7");

    upd(3'd1, 2'd0); tick("t6_dirty1");
    qry(3'd1, 2'd2); flush_i = 1'b1; tick("t6_flush_q");
    tick("t6_sweep1");
    tick("t6_sweep2");
    resetn_i = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(ready_o), 32'd1);
    chk("t6_rst_valid", 32'(victim_valid_o), 32'd0);
    chk("t6_rst_way", 32'(victim_way_o), 32'd0);
    @(negedge clock_i);
    resetn_i = 1'b1;
    @(posedge clock_i); #1;
    upd(3'd1, 2'd0); tick("t6_dirty1b");
    qry(3'd1, 2'd2); tick("t6_q1");
`ifdef TREE_PLRU_INVALID_FIRST_EN
    valid_i = 4'b1011;
    qry(3'd1, 2'd2); tick("t6_inv_q");
    chk("t6_inv_flag", 32'(victim_invalid_o), 32'd1);
    valid_i = 4'b1111;
    qry(3'd1, 2'd2); tick("t6_tree_q");
    chk("t6_tree_flag", 32'(victim_invalid_o), 32'd0);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
